multirate_v4_sdiv_24s_8s_16: RTL and testbench
==============================================

MULTIRATE_V4_SDIV_24S_8S_16 -- requirements
Module: multirate_v4_sdiv_24s_8s_16

Interface
REQ-001 The block SHALL have parameter DIVIDEND_WIDTH, default 24, width of the signed dividend (product domain).
REQ-002 The block SHALL have parameter DIVISOR_WIDTH, default 8, width of the signed divisor (coefficient domain).
REQ-003 The block SHALL have parameter QUOTIENT_WIDTH, default 16, width of the signed saturated quotient (sample domain).
REQ-004 The block SHALL have port ap_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port ap_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port in_valid, input, 1 bit: din0/din1 valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts an operand pair.
REQ-008 The block SHALL have port din0, input, DIVIDEND_WIDTH bits: signed dividend.
REQ-009 The block SHALL have port din1, input, DIVISOR_WIDTH bits: signed divisor.
REQ-010 The block SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-012 The block SHALL have port dout, output, QUOTIENT_WIDTH bits: signed quotient, truncated toward zero and saturated.
REQ-013 The block SHALL have port rem, output, DIVISOR_WIDTH bits: signed remainder; its sign SHALL follow the dividend.
REQ-014 The block SHALL have port ovf, output, 1 bit: the quotient was saturated.
REQ-015 The block SHALL have port dz, output, 1 bit: the divisor was zero.

Function
REQ-016 The block SHALL be a three-state FSM with states IDLE, CALC and DONE.
REQ-017 in_ready SHALL be 1 only in IDLE.
REQ-018 On in_valid & in_ready the block SHALL register |din0|, |din1|, both signs and a zero-divisor flag, then move to CALC.
REQ-019 In CALC the block SHALL perform exactly DIVIDEND_WIDTH restoring shift-subtract iterations, one per cycle, on the magnitudes, counted by an iteration counter.
REQ-020 After the last iteration the FSM SHALL go to DONE, where out_valid=1.
REQ-021 Latency SHALL be fixed at DIVIDEND_WIDTH+1 = 25 cycles from the accept edge to out_valid high, data-independent, including divide-by-zero.
REQ-022 Throughput SHALL be at most one operation per DIVIDEND_WIDTH+2 cycles, with no overlap.
REQ-023 In DONE, dout, rem, ovf and dz SHALL be held stable until out_valid & out_ready, after which the FSM returns to IDLE on the same edge.
REQ-024 in_ready SHALL NOT rise in the cycle of the out_valid & out_ready handshake; it rises the following cycle.
REQ-025 The quotient sign SHALL be sign(din0) XOR sign(din1), applied after the magnitude division.
REQ-026 A negative quotient with magnitude greater than 2^(QUOTIENT_WIDTH-1) SHALL saturate dout to -32768 and set ovf=1.
REQ-027 A positive quotient with magnitude greater than 2^(QUOTIENT_WIDTH-1)-1 SHALL saturate dout to 32767 and set ovf=1.
REQ-028 When din1 = 0: dz=1, ovf=1, rem=0, and dout = 32767 if din0 >= 0, else -32768.
REQ-029 For -2^23 / -1, dout SHALL be 32767 with ovf=1; the magnitude path SHALL be DIVIDEND_WIDTH+1 bits wide so that no intermediate value wraps.
REQ-030 For divisor -128 the magnitude SHALL be handled as 128 with no wrap; |rem| SHALL NOT exceed 127.
REQ-031 in_valid SHALL be ignored outside IDLE, and the operand registers SHALL NOT change.

Reset
REQ-032 Assertion of ap_rst_n=0 SHALL force, asynchronously: FSM state IDLE, counter 0, in_ready=0 while in reset, out_valid=0, dout=0, rem=0, ovf=0, dz=0.
REQ-033 After ap_rst_n deasserts, in_ready SHALL be 1 in the first cycle.
REQ-034 Reset during CALC or DONE SHALL discard the operation; no out_valid SHALL follow.

Structure
REQ-035 Package multirate_v4_div_pkg SHALL hold the width constants, the FSM state enum, and the SAT_MAX/SAT_MIN constants.
REQ-036 One combinational sub-module, multirate_v4_sdiv_step (single restoring iteration: shift, trial subtract, quotient bit), SHALL be instantiated once.

Verification
REQ-037 Bench scenario: 1000000 / 100 -> dout=10000, rem=0, ovf=0, dz=0, out_valid exactly 25 cycles after accept.
REQ-038 Bench scenario: -7/2 -> dout=-3, rem=-1; 7/-2 -> dout=-3, rem=1; -7/-2 -> dout=3, rem=-1.
REQ-039 Bench scenario: 5000000/3 -> dout=32767, ovf=1; -8388608/-1 -> dout=32767, ovf=1; -8388608/127 -> dout=-32768, ovf=1.
REQ-040 Bench scenario: 1234/0 -> dz=1, ovf=1, dout=32767, rem=0; -1/0 -> dout=-32768.
REQ-041 Bench scenario: out_ready held 0 for 10 cycles in DONE -> outputs stable, in_ready=0, in_valid pulses ignored; result delivered once when out_ready rises.
REQ-042 Bench scenario: ap_rst_n pulsed low at iteration 12 -> outputs zero immediately, no out_valid, next op 100/-128 -> dout=0, rem=100.

Source files
------------

// File: rtl/multirate_v4_div_pkg.sv
// rtl/multirate_v4_div_pkg.sv - widths, saturation limits and FSM states for the signed divider
package multirate_v4_div_pkg;

  localparam int DIVIDEND_WIDTH_C = 24;
  localparam int DIVISOR_WIDTH_C  = 8;
  localparam int QUOTIENT_WIDTH_C = 16;

  localparam logic [QUOTIENT_WIDTH_C-1:0] SAT_MAX = {1'b0, {(QUOTIENT_WIDTH_C-1){1'b1}}};
  localparam logic [QUOTIENT_WIDTH_C-1:0] SAT_MIN = {1'b1, {(QUOTIENT_WIDTH_C-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/multirate_v4_sdiv_step.sv
// rtl/multirate_v4_sdiv_step.sv - one restoring iteration: shift in a dividend bit, trial subtract
module multirate_v4_sdiv_step
  import multirate_v4_div_pkg::*;
#(
  parameter int DIVISOR_WIDTH = DIVISOR_WIDTH_C
) (
  input  logic [DIVISOR_WIDTH-1:0] rem_in,
  input  logic                     num_bit,
  input  logic [DIVISOR_WIDTH:0]   dvs,
  output logic [DIVISOR_WIDTH-1:0] rem_out,
  output logic                     q_bit
);

  logic [DIVISOR_WIDTH:0] shifted;

  // The partial remainder stays below the divisor magnitude (at most 128), so it fits
  // in DIVISOR_WIDTH bits; the shifted value needs one extra bit.
  always_comb begin
    shifted = {rem_in, num_bit};
    q_bit   = (shifted >= dvs);
    rem_out = q_bit ? DIVISOR_WIDTH'(shifted - dvs) : DIVISOR_WIDTH'(shifted);
  end

endmodule

// File: rtl/multirate_v4_sdiv_24s_8s_16.sv
// rtl/multirate_v4_sdiv_24s_8s_16.sv - multi-cycle signed divider, truncating, saturated quotient
module multirate_v4_sdiv_24s_8s_16
  import multirate_v4_div_pkg::*;
#(
  parameter int DIVIDEND_WIDTH = DIVIDEND_WIDTH_C,
  parameter int DIVISOR_WIDTH  = DIVISOR_WIDTH_C,
  parameter int QUOTIENT_WIDTH = QUOTIENT_WIDTH_C
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DIVIDEND_WIDTH-1:0] din0,
  input  logic [DIVISOR_WIDTH-1:0]  din1,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [QUOTIENT_WIDTH-1:0] dout,
  output logic [DIVISOR_WIDTH-1:0]  rem,
  output logic                      ovf,
  output logic                      dz
);

  localparam int CW = $clog2(DIVIDEND_WIDTH + 1);
  localparam logic [DIVIDEND_WIDTH:0] ONE_W   = 1;
  localparam logic [DIVIDEND_WIDTH:0] NEG_LIM = ONE_W << (QUOTIENT_WIDTH - 1);
  localparam logic [DIVIDEND_WIDTH:0] POS_LIM = NEG_LIM - ONE_W;

  div_state_e state_q, state_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic [DIVIDEND_WIDTH:0]     num_q, num_d;
  logic [DIVIDEND_WIDTH:0]     quo_q, quo_d;
  logic [DIVISOR_WIDTH-1:0]    prem_q, prem_d;
  logic [DIVISOR_WIDTH:0]      dvs_q, dvs_d;
  logic                        s0_q, s0_d;
  logic                        s1_q, s1_d;
  logic                        zero_q, zero_d;
  logic [QUOTIENT_WIDTH-1:0]   dout_q, dout_d;
  logic [DIVISOR_WIDTH-1:0]    rem_q, rem_d;
  logic                        ovf_q, ovf_d;
  logic                        dz_q, dz_d;

  logic [DIVIDEND_WIDTH:0]     a_ext, a_mag;
  logic [DIVISOR_WIDTH:0]      b_ext, b_mag;
  logic [DIVISOR_WIDTH-1:0]    step_rem;
  logic                        step_q;
  logic [QUOTIENT_WIDTH-1:0]   q_low;
  logic [QUOTIENT_WIDTH-1:0]   res_dout;
  logic [DIVISOR_WIDTH-1:0]    res_rem;
  logic                        res_ovf;

  assign in_ready  = (state_q == ST_IDLE) && ap_rst_n;
  assign out_valid = (state_q == ST_DONE);
  assign dout      = dout_q;
  assign rem       = rem_q;
  assign ovf       = ovf_q;
  assign dz        = dz_q;

  // Magnitudes are one bit wider than the operands so -2^23 and -128 do not wrap.
  always_comb begin
    a_ext = {din0[DIVIDEND_WIDTH-1], din0};
    b_ext = {din1[DIVISOR_WIDTH-1], din1};
    a_mag = din0[DIVIDEND_WIDTH-1] ? -a_ext : a_ext;
    b_mag = din1[DIVISOR_WIDTH-1]  ? -b_ext : b_ext;
  end

  multirate_v4_sdiv_step #(
    .DIVISOR_WIDTH (DIVISOR_WIDTH)
  ) u_step (
    .rem_in  (prem_q),
    .num_bit (num_q[DIVIDEND_WIDTH-1]),
    .dvs     (dvs_q),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  // Sign is applied after the magnitude division, then the quotient is clamped.
  always_comb begin
    q_low    = quo_q[QUOTIENT_WIDTH-1:0];
    res_dout = q_low;
    res_ovf  = 1'b0;
    res_rem  = s0_q ? -prem_q : prem_q;
    if (zero_q) begin
      res_ovf  = 1'b1;
      res_dout = s0_q ? SAT_MIN : SAT_MAX;
      res_rem  = '0;
    end else if (s0_q ^ s1_q) begin
      if (quo_q > NEG_LIM) begin
        res_ovf  = 1'b1;
        res_dout = SAT_MIN;
      end else begin
        res_dout = -q_low;
      end
    end else if (quo_q > POS_LIM) begin
      res_ovf  = 1'b1;
      res_dout = SAT_MAX;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    quo_d   = quo_q;
    prem_d  = prem_q;
    dvs_d   = dvs_q;
    s0_d    = s0_q;
    s1_d    = s1_q;
    zero_d  = zero_q;
    dout_d  = dout_q;
    rem_d   = rem_q;
    ovf_d   = ovf_q;
    dz_d    = dz_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          state_d = ST_CALC;
          cnt_d   = '0;
          num_d   = a_mag;
          dvs_d   = b_mag;
          quo_d   = '0;
          prem_d  = '0;
          s0_d    = din0[DIVIDEND_WIDTH-1];
          s1_d    = din1[DIVISOR_WIDTH-1];
          zero_d  = (din1 == '0);
        end
      end
      ST_CALC: begin
        // DIVIDEND_WIDTH iterations, then one cycle to sign, clamp and register results.
        if (cnt_q == CW'(DIVIDEND_WIDTH)) begin
          state_d = ST_DONE;
          cnt_d   = '0;
          dout_d  = res_dout;
          rem_d   = res_rem;
          ovf_d   = res_ovf;
          dz_d    = zero_q;
        end else begin
          cnt_d  = cnt_q + CW'(1);
          num_d  = num_q << 1;
          quo_d  = {quo_q[DIVIDEND_WIDTH-1:0], step_q};
          prem_d = step_rem;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      num_q   <= '0;
      quo_q   <= '0;
      prem_q  <= '0;
      dvs_q   <= '0;
      s0_q    <= 1'b0;
      s1_q    <= 1'b0;
      zero_q  <= 1'b0;
      dout_q  <= '0;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      quo_q   <= quo_d;
      prem_q  <= prem_d;
      dvs_q   <= dvs_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      zero_q  <= zero_d;
      dout_q  <= dout_d;
      rem_q   <= rem_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
    end
  end

endmodule

// File: tb/tb_multirate_v4_sdiv_24s_8s_16.sv
// tb/tb_multirate_v4_sdiv_24s_8s_16.sv - randomized self-checking bench against an arithmetic model
module tb_multirate_v4_sdiv_24s_8s_16;

  localparam int DW = 24;
  localparam int VW = 8;
  localparam int QW = 16;

  logic          ap_clk    = 1'b0;
  logic          ap_rst_n  = 1'b0;
  logic          in_valid  = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] din0      = '0;
  logic [VW-1:0] din1      = '0;
  logic          in_ready;
  logic          out_valid;
  logic [QW-1:0] dout;
  logic [VW-1:0] rem;
  logic          ovf;
  logic          dz;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int q;
    int r;
    int ovf;
    int dz;
  } res_t;

  res_t exp_q[$];

  multirate_v4_sdiv_24s_8s_16 dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din0      (din0),
    .din1      (din1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .rem       (rem),
    .ovf       (ovf),
    .dz        (dz)
  );

  always #5 ap_clk = ~ap_clk;

  // Integer division in SV truncates toward zero and % follows the dividend's sign.
  function automatic res_t model(input int a, input int b);
    res_t r;
    int q;
    if (b == 0) begin
      r.dz  = 1;
      r.ovf = 1;
      r.r   = 0;
      r.q   = (a < 0) ? -32768 : 32767;
    end else begin
      q     = a / b;
      r.dz  = 0;
      r.r   = a % b;
      r.ovf = (q > 32767 || q < -32768) ? 1 : 0;
      r.q   = (q > 32767) ? 32767 : ((q < -32768) ? -32768 : q);
    end
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  always @(negedge ap_clk) begin
    if (ap_rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected out_valid", 1, 0);
      end else begin
        chk("dout", $signed(dout), exp_q[0].q);
        chk("rem", $signed(rem), exp_q[0].r);
        chk("ovf", int'(ovf), exp_q[0].ovf);
        chk("dz", int'(dz), exp_q[0].dz);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic do_op(input int a, input int b, input int stall, input bit junk);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge ap_clk); #1;
      n++;
    end
    if (!in_ready) chk("in_ready wait", 0, 1);
    din0      = a[DW-1:0];
    din1      = b[VW-1:0];
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge ap_clk);
    exp_q.push_back(model(a, b));
    #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 60) begin
      @(posedge ap_clk); #1;
      n++;
    end
    chk("latency", n, 25);
    if (out_valid) begin
      for (int i = 0; i < stall; i++) begin
        if (junk) begin
          din0     = DW'($urandom);
          din1     = VW'($urandom);
          in_valid = 1'b1;
        end
        chk("in_ready in DONE", int'(in_ready), 0);
        chk("out_valid held", int'(out_valid), 1);
        @(posedge ap_clk); #1;
        in_valid = 1'b0;
      end
      out_ready = 1'b1;
      @(posedge ap_clk); #1;
      out_ready = 1'b0;
      chk("out_valid after handshake", int'(out_valid), 0);
      chk("in_ready after handshake", int'(in_ready), 1);
    end
  endtask

  task automatic run_lit(input int a, input int b, input int eq, input int er, input int eo, input int ez);
    res_t r;
    r = model(a, b);
    chk("model q", r.q, eq);
    chk("model r", r.r, er);
    chk("model ovf", r.ovf, eo);
    chk("model dz", r.dz, ez);
    do_op(a, b, 0, 1'b0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    #12;
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset in_ready", int'(in_ready), 0);
    chk("reset dout", int'(dout), 0);
    chk("reset rem", int'(rem), 0);
    chk("reset ovf", int'(ovf), 0);
    chk("reset dz", int'(dz), 0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    #1;
    chk("in_ready after reset", int'(in_ready), 1);

    run_lit(1000000, 100, 10000, 0, 0, 0);
    run_lit(-7, 2, -3, -1, 0, 0);
    run_lit(7, -2, -3, 1, 0, 0);
    run_lit(-7, -2, 3, -1, 0, 0);
    run_lit(5000000, 3, 32767, 2, 1, 0);
    run_lit(-8388608, -1, 32767, 0, 1, 0);
    run_lit(-8388608, 127, -32768, -4, 1, 0);
    run_lit(1234, 0, 32767, 0, 1, 1);
    run_lit(-1, 0, -32768, 0, 1, 1);
    run_lit(-32768, 1, -32768, 0, 0, 0);
    run_lit(32768, 1, 32767, 0, 1, 0);
    run_lit(-32769, 1, -32768, 0, 1, 0);
    run_lit(32767, 1, 32767, 0, 0, 0);

    do_op(321, -9, 10, 1'b1);

    // Abort an operation mid-iteration with an asynchronous reset.
    din0     = DW'(1000);
    din1     = VW'(7);
    in_valid = 1'b1;
    @(posedge ap_clk); #1;
    in_valid = 1'b0;
    repeat (12) @(posedge ap_clk);
    #2;
    ap_rst_n = 1'b0;
    #1;
    chk("mid reset out_valid", int'(out_valid), 0);
    chk("mid reset in_ready", int'(in_ready), 0);
    chk("mid reset dout", int'(dout), 0);
    chk("mid reset rem", int'(rem), 0);
    chk("mid reset ovf", int'(ovf), 0);
    chk("mid reset dz", int'(dz), 0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    #1;
    chk("in_ready after mid reset", int'(in_ready), 1);
    seen = 0;
    repeat (30) begin
      @(posedge ap_clk); #1;
      if (out_valid) seen++;
    end
    chk("no out_valid after reset", seen, 0);
    run_lit(100, -128, 0, 100, 0, 0);

    for (int k = 0; k < 150; k++) begin
      int a;
      int b;
      if ($urandom_range(0, 2) == 0) a = $urandom_range(0, 16777215) - 8388608;
      else a = int'($urandom_range(0, 400000)) - 200000;
      if ($urandom_range(0, 15) == 0) b = 0;
      else b = int'($urandom_range(0, 255)) - 128;
      do_op(a, b, int'($urandom_range(0, 3)), 1'b1);
    end

    repeat (3) @(posedge ap_clk);
    chk("results pending", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
